sha256_core: RTL and testbench
==============================

Name: sha256_core

Overview:
- Iterative SHA-256 compression engine. Accepts one 512-bit message block plus a 256-bit chaining value and returns the updated 256-bit digest.
- Built on the existing round primitives: ch, maj, l0/l1 (Σ0/Σ1) and s0/s1 (σ0/σ1).
- Parametrised by rounds unrolled per clock, trading area for latency.
- Sits under the mining controller, which feeds header blocks and chains digests.

Parameters:
- ROUNDS_PER_CYCLE, 1: rounds evaluated per clock. Legal values are 1, 2, 4, 8; any other value is an elaboration error.
- NUM_CYCLES, 64/ROUNDS_PER_CYCLE: derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- ready  out  1  core idle and able to accept start.
- use_iv  in  1  1: chain from the standard SHA-256 IV; 0: chain from hash_in. Sampled with start.
- hash_in  in  256  chaining value H0..H7, H0 in [255:224]. Sampled with start.
- block_in  in  512  message words W0..W15, W0 in [511:480], big-endian. Sampled with start.
- hash_out  out  256  digest, same packing as hash_in.
- done  out  1  one-cycle pulse; hash_out is valid from this cycle.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - ready=1, done=0, hash_out=0, FSM=IDLE.
  - Working registers a..h and the schedule window are cleared.
- FSM states: IDLE, ROUND, FINAL.
  - IDLE: ready=1. When start=1 on a clock edge:
    - Load a..h from the chaining value (IV or hash_in).
    - Latch the chaining value and block_in into the 16-word window W.
    - Clear the round counter; go to ROUND.
  - ROUND: ready=0. Each edge performs ROUNDS_PER_CYCLE rounds t..t+R-1 and advances the counter by R. After the edge completing round 63, go to FINAL.
  - FINAL: one edge.
    - hash_out <= latched chaining value + {a..h}, word-wise mod 2^32.
    - done=1 in the following cycle; go to IDLE.
- Latency: start edge at N → done high in the cycle after edge N+NUM_CYCLES+1 (R=1: 65 edges; R=4: 17).
- ready rises in the same cycle as done. A start in that cycle is accepted, giving back-to-back throughput of NUM_CYCLES+2 cycles per block.
- start while ready=0 is ignored; no queuing.
- Arithmetic:
  - All additions are 32-bit modulo 2^32; carries discarded.
  - Round: T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = Σ0(a) + Maj(a,b,c).
  - Schedule for t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - The window shifts by R words per cycle. Rounds 0..15 consume block_in words directly.
- hash_out holds its value until the next FINAL, independent of inputs.
- Reset mid-operation aborts the hash: no done, and hash_out returns to 0.
- Inputs may change after the start edge; the core uses only latched copies.

Optional Feature:
- Macro SHA256_DOUBLE_EN.
- Defined:
  - Extra input port dbl (1 bit), sampled with start.
  - If dbl=1, after the first FINAL the core does not raise done. It restarts ROUND with:
    - IV as the chaining value.
    - Block = first digest || 80000000 || six zero words || 00000100.
  - done and hash_out report only the second digest (SHA256d). Latency is 2*(NUM_CYCLES+1).
  - dbl=0 behaves as the single-pass core.
- Undefined: no dbl port; single pass only.

Decomposition:
- Package sha256_pkg holds:
  - The 64-entry K constant table.
  - The 8-word IV.
  - The 32-bit word typedef.
  - The FSM state enum.
- Sub-module sha256_round: one combinational round (a..h, K, W in → a..h out) built from ch/maj/l0/l1. It is instantiated ROUNDS_PER_CYCLE times in a chain.
- Schedule expansion stays inline using s0/s1.

Test Plan:
- "abc": block 61626380, 14 zero words, 00000018; use_iv=1, R=1 → hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done exactly 65 edges after start.
- Empty message (80000000, zeros, length 0) with R=4 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; done after 17 edges.
- Two-block "abcdbcde…nopq" (448-bit):
  - Block 1 with use_iv=1; block 2 (padding, length 000001c0) with use_iv=0 and hash_in = digest 1.
  - Final digest must be 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Back-to-back and busy handling:
  - Hold start=1 continuously → one done per NUM_CYCLES+2 cycles.
  - Toggle block_in during ROUND → digest unaffected.
  - start while busy is ignored.
- Reset mid-ROUND at round 30 → ready=1, done=0, hash_out=0 immediately. A subsequent "abc" run is still correct.
- SHA256_DOUBLE_EN defined, dbl=1, empty-message block → single done with 5df6e0e2 761359d3 0a827505 8e299fcc 03815345 45f55cf4 3e41983f 5d4c9456.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, constants and round primitives.
//   word_t    32-bit message/state word
//   hash_t    eight words packed as H0..H7, H0 in [255:224] (index 7)
//   window_t  sixteen words; as a message block, W0 sits in [511:480]
//   state_t   core FSM states
//   K, IV     round constants and standard initial hash value
//   ch/maj/l0/l1/s0/s1  round primitives (l = big sigma, s = small sigma)
package sha256_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [7:0][31:0]  hash_t;
  typedef logic [15:0][31:0] window_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t l0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t l1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Word-wise modulo-2^32 sum of two hash states.
  function automatic hash_t hash_add(input hash_t x, input hash_t y);
    hash_t r;
    for (int unsigned i = 0; i < 8; i++) r[i] = x[i] + y[i];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round.
//   v_in   working state a..h (a in [255:224])
//   k      round constant K[t]
//   w      schedule word W[t]
//   v_out  working state after the round
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t v_in,
  input  word_t k,
  input  word_t w,
  output hash_t v_out
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  assign {a, b, c, d, e, f, g, h} = v_in;

  assign t1 = h + l1(e) + ch(e, f, g) + k + w;
  assign t2 = l0(a) + maj(a, b, c);

  assign v_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_core.sv
// sha256_core: iterative SHA-256 compression engine, ROUNDS_PER_CYCLE
// rounds (1, 2, 4 or 8) per clock.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, accepted when ready=1
//   ready       idle, able to accept start
//   use_iv      1: chain from standard IV, 0: from hash_in (sampled with start)
//   hash_in     chaining value H0..H7, H0 in [255:224]
//   block_in    message words W0..W15, W0 in [511:480]
//   hash_out    digest, same packing as hash_in; held until next completion
//   done        one-cycle pulse, hash_out valid from this cycle
//   dbl         (SHA256_DOUBLE_EN only) 1: return SHA256d of the block
module sha256_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic         use_iv,
  input  logic [255:0] hash_in,
  input  logic [511:0] block_in,
`ifdef SHA256_DOUBLE_EN
  input  logic         dbl,
`endif
  output logic [255:0] hash_out,
  output logic         done
);

  localparam int unsigned NUM_CYCLES = 64 / ROUNDS_PER_CYCLE;
  localparam logic [5:0]  LAST_T     = 6'((NUM_CYCLES - 1) * ROUNDS_PER_CYCLE);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
    $error("sha256_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t     state, state_nxt;
  logic [5:0] t;
  hash_t      vars;
  hash_t      chain_h;
  window_t    win, win_nxt;
  window_t    blk;
  hash_t      rnd [ROUNDS_PER_CYCLE + 1];
  hash_t      sum;
  logic       dbl_pend;

  assign blk = block_in;

  // Window holds W[t..t+15] in win[0..15]. Advancing by R words needs R new
  // schedule words; for R>2 later new words depend on earlier new ones, so
  // they are built in order in a local extended array.
  function automatic window_t next_window(input window_t cur);
    word_t ext [24];
    for (int unsigned i = 0; i < 24; i++) ext[i] = '0;
    for (int unsigned i = 0; i < 16; i++) ext[i] = cur[i];
    for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++)
      ext[16 + j] = s1(ext[14 + j]) + ext[9 + j] + s0(ext[1 + j]) + ext[j];
    for (int unsigned i = 0; i < 16; i++) next_window[i] = ext[i + ROUNDS_PER_CYCLE];
  endfunction

  assign win_nxt = next_window(win);

  assign rnd[0] = vars;
  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
    sha256_round u_round (
      .v_in  (rnd[i]),
      .k     (K[t + 6'(i)]),
      .w     (win[i]),
      .v_out (rnd[i + 1])
    );
  end

  assign sum   = hash_add(chain_h, vars);
  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROUND;
      ROUND:   if (t == LAST_T) state_nxt = FINAL;
      FINAL:   state_nxt = dbl_pend ? ROUND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SHA256_DOUBLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      dbl_pend <= 1'b0;
    else if (state == IDLE && start) dbl_pend <= dbl;
    else if (state == FINAL)         dbl_pend <= 1'b0;
  end
`else
  assign dbl_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vars     <= '0;
      chain_h  <= '0;
      win      <= '0;
      t        <= '0;
      hash_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            chain_h <= use_iv ? IV : hash_t'(hash_in);
            vars    <= use_iv ? IV : hash_t'(hash_in);
            for (int unsigned j = 0; j < 16; j++) win[j] <= blk[15 - j];
            t <= '0;
          end
        end
        ROUND: begin
          vars <= rnd[ROUNDS_PER_CYCLE];
          win  <= win_nxt;
          t    <= t + 6'(ROUNDS_PER_CYCLE);
        end
        FINAL: begin
          if (dbl_pend) begin
            // Second pass: hash the 256-bit first digest as a padded block.
            chain_h <= IV;
            vars    <= IV;
            for (int unsigned j = 0; j < 8; j++) win[j] <= sum[7 - j];
            win[8] <= 32'h80000000;
            for (int unsigned j = 9; j < 15; j++) win[j] <= '0;
            win[15] <= 32'h00000100;
            t <= '0;
          end else begin
            hash_out <= sum;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// tb_sha256_core: runs an R=1 and an R=4 core side by side on the same
// inputs and checks digests, latency and handshake against a plain FIPS-style
// SHA-256 compression model. Define SHA256_DOUBLE_EN to also cover SHA256d.
module tb_sha256_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         use_iv = 1'b0;
  logic [255:0] hash_in = '0;
  logic [511:0] block_in = '0;
`ifdef SHA256_DOUBLE_EN
  logic         dbl = 1'b0;
`endif
  logic         ready1, done1, ready4, done4;
  logic [255:0] hout1, hout4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sha256_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready1), .use_iv(use_iv),
    .hash_in(hash_in), .block_in(block_in),
`ifdef SHA256_DOUBLE_EN
    .dbl(dbl),
`endif
    .hash_out(hout1), .done(done1));

  sha256_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready4), .use_iv(use_iv),
    .hash_in(hash_in), .block_in(block_in),
`ifdef SHA256_DOUBLE_EN
    .dbl(dbl),
`endif
    .hash_out(hout4), .done(done4));

  int unsigned KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_C = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_EXP   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_EXP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_EXP = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA256_DOUBLE_EN
  localparam logic [255:0] DBL_EXP = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
`endif

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int unsigned ror(input int unsigned x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-entry schedule, then 64 rounds.
  function automatic logic [255:0] ref_compress(input logic [255:0] hv, input logic [511:0] blk);
    int unsigned w [64];
    int unsigned v [8];
    int unsigned hw [8];
    int unsigned t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) begin hw[i] = hv[255 - 32*i -: 32]; v[i] = hw[i]; end
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hw[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; inputs are scrambled after the start edge, optional start
  // pokes while busy must be ignored.
  task automatic run_one(input string tag, input logic iv, input logic [255:0] hin,
                         input logic [511:0] blk, input logic [255:0] exp,
                         input int lat1_exp, input int lat4_exp, input bit poke);
    int lat1 = 0, lat4 = 0, cnt1 = 0, cnt4 = 0;
    logic [255:0] h1 = '0, h4 = '0;
    use_iv = iv; hash_in = hin; block_in = blk; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= lat1_exp + 5; c++) begin
      hash_in  = {rand_block()}[255:0];
      block_in = rand_block();
      use_iv   = 1'($urandom_range(1));
      start    = (poke && c >= 2 && c <= 9 && c % 3 == 0);
      tick();
      if (done1) begin cnt1++; if (lat1 == 0) begin lat1 = c; h1 = hout1; end end
      if (done4) begin cnt4++; if (lat4 == 0) begin lat4 = c; h4 = hout4; end end
    end
    start = 1'b0;
    check({tag, " r1 digest"}, h1, exp);
    check({tag, " r4 digest"}, h4, exp);
    check({tag, " r1 latency"}, 256'(lat1), 256'(lat1_exp));
    check({tag, " r4 latency"}, 256'(lat4), 256'(lat4_exp));
    check({tag, " r1 done count"}, 256'(cnt1), 256'd1);
    check({tag, " r4 done count"}, 256'(cnt4), 256'd1);
  endtask

  initial begin
    logic [255:0] d1, hin, exp;
    logic [511:0] blk;
    logic iv;
    int t1q [$];
    int t4q [$];
    int cnt;

    repeat (3) tick();
    check("reset ready1", 256'(ready1), 256'd1);
    check("reset ready4", 256'(ready4), 256'd1);
    check("reset done1", 256'(done1), 256'd0);
    check("reset done4", 256'(done4), 256'd0);
    check("reset hout1", hout1, '0);
    check("reset hout4", hout4, '0);
    rst_n = 1'b1;
    tick();

    run_one("abc", 1'b1, '0, ABC_BLK, ABC_EXP, 65, 17, 1'b0);
    run_one("empty", 1'b1, '0, EMPTY_BLK, EMPTY_EXP, 65, 17, 1'b0);
    d1 = ref_compress(IV_C, TWO_B1);
    run_one("two blk1", 1'b1, '0, TWO_B1, d1, 65, 17, 1'b0);
    run_one("two blk2", 1'b0, d1, TWO_B2, TWO_EXP, 65, 17, 1'b0);
    run_one("busy start", 1'b1, '0, ABC_BLK, ABC_EXP, 65, 17, 1'b1);

    for (int r = 0; r < 4; r++) begin
      blk = rand_block();
      hin = {rand_block()}[255:0];
      iv  = 1'($urandom_range(1));
      exp = ref_compress(iv ? IV_C : hin, blk);
      run_one($sformatf("rand%0d", r), iv, hin, blk, exp, 65, 17, 1'b0);
    end

    // Held start: each core restarts as soon as it is ready.
    use_iv = 1'b1; hash_in = '0; block_in = ABC_BLK; start = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      tick();
      if (done1) begin t1q.push_back(c); check("hold r1 digest", hout1, ABC_EXP); end
      if (done4) begin t4q.push_back(c); check("hold r4 digest", hout4, ABC_EXP); end
    end
    start = 1'b0;
    check("hold r1 gap", (t1q.size() >= 2) ? 256'(t1q[1] - t1q[0]) : '0, 256'd66);
    check("hold r4 gap a", (t4q.size() >= 3) ? 256'(t4q[1] - t4q[0]) : '0, 256'd18);
    check("hold r4 gap b", (t4q.size() >= 3) ? 256'(t4q[2] - t4q[1]) : '0, 256'd18);
    for (int c = 0; c < 150; c++) begin
      if (ready1 && ready4) break;
      tick();
    end
    check("drain ready1", 256'(ready1), 256'd1);
    check("drain ready4", 256'(ready4), 256'd1);

    // Reset partway through: R=1 core at round 30, R=4 core already finished.
    use_iv = 1'b1; block_in = EMPTY_BLK; start = 1'b1;
    tick();
    start = 1'b0;
    block_in = rand_block();
    repeat (30) tick();
    check("mid hout4 held", hout4, EMPTY_EXP);
    rst_n = 1'b0;
    #1;
    check("mid rst ready1", 256'(ready1), 256'd1);
    check("mid rst done1", 256'(done1), 256'd0);
    check("mid rst hout1", hout1, '0);
    check("mid rst hout4", hout4, '0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (done1 || done4) cnt++;
    end
    check("mid rst no done", 256'(cnt), 256'd0);
    run_one("abc after rst", 1'b1, '0, ABC_BLK, ABC_EXP, 65, 17, 1'b0);

`ifdef SHA256_DOUBLE_EN
    dbl = 1'b1;
    run_one("sha256d empty", 1'b1, '0, EMPTY_BLK, DBL_EXP, 130, 34, 1'b0);
    blk = rand_block();
    d1  = ref_compress(IV_C, blk);
    exp = ref_compress(IV_C, {d1, 32'h80000000, 192'h0, 32'h00000100});
    run_one("sha256d rand", 1'b1, '0, blk, exp, 130, 34, 1'b0);
    dbl = 1'b0;
    run_one("dbl0 abc", 1'b1, '0, ABC_BLK, ABC_EXP, 65, 17, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
